battleship_turn_ctrl: RTL and testbench

Turn scheduler and shot arbiter for the 5x5 Battleship game. It holds both fleet boards and shares the single shot-apply datapath between two requesters: the player input path and the CPU move generator. It alternates turns, accepts one shot per turn over a valid/ready handshake, clears hit cells and tracks remaining ship cells per board. It declares the winner when a fleet reaches zero and sits between the input/CPU logic and the display/score logic.

---
 rtl/battleship_turn_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_battleship_turn_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl
//   Turn scheduler and shot arbiter for the NxN Battleship game. It holds both
//   fleet boards and alternates turns between the player and the CPU. Each turn
//   accepts one shot through a valid/ready handshake. A hit clears the ship cell
//   and decrements that fleet's remaining-cell count. When a fleet reaches zero
//   the game moves to OVER and reports the winner.
//
//   Optional feature: define TURN_TIMEOUT_EN to make a side forfeit its turn
//   after TURN_CYCLES cycles without a shot.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin game (accepted in IDLE / OVER only)
//   p_board_in, c_board_in    fleets, bit r*N+c = ship at (r,c); latched on start
//   p_valid/p_row/p_col       player shot at the CPU board
//   p_ready                   player shot may be accepted this cycle
//   c_valid/c_row/c_col       CPU shot at the player board
//   c_ready                   CPU shot may be accepted this cycle
//   turn                      0 = player, 1 = CPU
//   shot_done                 one-cycle pulse: a shot was applied or forfeited
//   shot_hit, forfeit         qualifiers of shot_done
//   player_left, cpu_left     remaining ship cells per fleet
//   game_over, winner         game finished / winning side (0 = player)
//   state                     FSM encoding for debug
module battleship_turn_ctrl #(
  parameter int N           = 5,
  parameter int TURN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N-1:0]   p_board_in,
  input  logic [N*N-1:0]   c_board_in,
  input  logic             p_valid,
  input  logic [2:0]       p_row,
  input  logic [2:0]       p_col,
  output logic             p_ready,
  input  logic             c_valid,
  input  logic [2:0]       c_row,
  input  logic [2:0]       c_col,
  output logic             c_ready,
  output logic             turn,
  output logic             shot_done,
  output logic             shot_hit,
  output logic             forfeit,
  output logic [4:0]       player_left,
  output logic [4:0]       cpu_left,
  output logic             game_over,
  output logic             winner,
  output logic [2:0]       state
);

  localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_TURN = 3'd1,
    C_TURN = 3'd2,
    SWITCH = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t st_q, st_d;

  logic [N*N-1:0] p_board_q, c_board_q;
  logic [4:0]     p_pop, c_pop;
  logic [IW-1:0]  p_idx, c_idx;
  logic           p_in_range, c_in_range;
  logic           p_hit, c_hit;
  logic           load, apply_p, apply_c, expire, tmo_last;

  function automatic logic [4:0] popcount(input logic [N*N-1:0] b);
    logic [4:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < N * N; i++) sum = sum + 5'(b[i]);
    return sum;
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return IW'(r) * IW'(N) + IW'(c);
  endfunction

  assign p_pop = popcount(p_board_in);
  assign c_pop = popcount(c_board_in);

  // Coordinates outside the board count as a miss; the index is only used
  // when both coordinates are in range.
  assign p_in_range = (32'(p_row) < N) && (32'(p_col) < N);
  assign c_in_range = (32'(c_row) < N) && (32'(c_col) < N);
  assign p_idx      = cell_idx(p_row, p_col);
  assign c_idx      = cell_idx(c_row, c_col);
  assign p_hit      = p_in_range && c_board_q[p_idx];
  assign c_hit      = c_in_range && p_board_q[c_idx];

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TURN_CYCLES) + 1;
  logic [TW-1:0] tcnt;

  // Every turn state is entered from a non-turn state, so clearing outside
  // the turn states is equivalent to clearing on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (st_q == P_TURN || st_q == C_TURN) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign tmo_last = (tcnt == TW'(TURN_CYCLES - 1));
`else
  assign tmo_last = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d    = st_q;
    p_ready = 1'b0;
    c_ready = 1'b0;
    load    = 1'b0;
    apply_p = 1'b0;
    apply_c = 1'b0;
    expire  = 1'b0;
    unique case (st_q)
      IDLE, OVER: begin
        if (start) begin
          load = 1'b1;
          st_d = (p_pop == '0 || c_pop == '0) ? OVER : P_TURN;
        end
      end
      P_TURN: begin
        p_ready = 1'b1;
        if (p_valid) begin
          apply_p = 1'b1;
          st_d    = SWITCH;
        end else if (tmo_last) begin
          expire = 1'b1;
          st_d   = SWITCH;
        end
      end
      C_TURN: begin
        c_ready = 1'b1;
        if (c_valid) begin
          apply_c = 1'b1;
          st_d    = SWITCH;
        end else if (tmo_last) begin
          expire = 1'b1;
          st_d   = SWITCH;
        end
      end
      SWITCH: begin
        // turn still names the side that just shot
        if (turn ? (player_left == '0) : (cpu_left == '0)) st_d = OVER;
        else st_d = turn ? P_TURN : C_TURN;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_board_q   <= '0;
      c_board_q   <= '0;
      player_left <= '0;
      cpu_left    <= '0;
      turn        <= 1'b0;
      winner      <= 1'b0;
      shot_done   <= 1'b0;
      shot_hit    <= 1'b0;
    end else begin
      shot_done <= apply_p | apply_c | expire;
      shot_hit  <= (apply_p & p_hit) | (apply_c & c_hit);
      if (load) begin
        p_board_q   <= p_board_in;
        c_board_q   <= c_board_in;
        player_left <= p_pop;
        cpu_left    <= c_pop;
        turn        <= 1'b0;
        // An empty player fleet loses unless both are empty (tie -> player).
        winner      <= (p_pop == '0) && (c_pop != '0);
      end
      if (apply_p && p_hit) begin
        c_board_q[p_idx] <= 1'b0;
        cpu_left         <= cpu_left - 1'b1;
      end
      if (apply_c && c_hit) begin
        p_board_q[c_idx] <= 1'b0;
        player_left      <= player_left - 1'b1;
      end
      if (st_q == SWITCH) begin
        if (st_d == OVER) winner <= turn;
        else              turn   <= ~turn;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) forfeit <= 1'b0;
    else     forfeit <= expire;
  end
`else
  assign forfeit = 1'b0;
`endif

  assign game_over = (st_q == OVER);
  assign state     = st_q;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
module tb_battleship_turn_ctrl;

  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [N*N-1:0] p_board_in, c_board_in;
  logic           p_valid, c_valid;
  logic [2:0]     p_row, p_col, c_row, c_col;
  logic           p_ready, c_ready, turn, shot_done, shot_hit, forfeit;
  logic [4:0]     player_left, cpu_left;
  logic           game_over, winner;
  logic [2:0]     state;

  battleship_turn_ctrl #(.N(N), .TURN_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p_board_in(p_board_in), .c_board_in(c_board_in),
    .p_valid(p_valid), .p_row(p_row), .p_col(p_col), .p_ready(p_ready),
    .c_valid(c_valid), .c_row(c_row), .c_col(c_col), .c_ready(c_ready),
    .turn(turn), .shot_done(shot_done), .shot_hit(shot_hit), .forfeit(forfeit),
    .player_left(player_left), .cpu_left(cpu_left),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       forf;
    logic [4:0] pl;
    logic [4:0] cl;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every shot_done pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (shot_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_shot_done", 32'(shot_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("shot_hit",    32'(shot_hit),    32'(e.hit));
          chk("forfeit",     32'(forfeit),     32'(e.forf));
          chk("player_left", 32'(player_left), 32'(e.pl));
          chk("cpu_left",    32'(cpu_left),    32'(e.cl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N*N-1:0] pb, input logic [N*N-1:0] cb);
    p_board_in = pb;
    c_board_in = cb;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drive one accepted shot; the expected response goes to the scoreboard.
  task automatic shot(input bit cpu, input logic [2:0] r, input logic [2:0] c,
                      input logic hit, input logic [4:0] pl, input logic [4:0] cl);
    exp_t e;
    e = '{hit: hit, forf: 1'b0, pl: pl, cl: cl};
    exp_q.push_back(e);
    if (cpu) begin c_valid = 1'b1; c_row = r; c_col = c; end
    else     begin p_valid = 1'b1; p_row = r; p_col = c; end
    step();
    p_valid = 1'b0;
    c_valid = 1'b0;
    chk("state_switch", 32'(state), 32'd3);
    chk("ready_switch", 32'({p_ready, c_ready}), 32'd0);
  endtask

  localparam logic [N*N-1:0] PB1 = 25'h1;               // (0,0)
  localparam logic [N*N-1:0] CB1 = 25'h1040;            // (1,1),(2,2)

  initial begin
    rst = 1'b1; start = 1'b0; p_valid = 1'b0; c_valid = 1'b0;
    p_row = '0; p_col = '0; c_row = '0; c_col = '0;
    p_board_in = '0; c_board_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",  32'(state), 32'd0);
    chk("rst_ready",  32'({p_ready, c_ready}), 32'd0);
    chk("rst_counts", 32'({player_left, cpu_left}), 32'd0);
    chk("rst_flags",  32'({turn, shot_done, shot_hit, forfeit, game_over, winner}), 32'd0);
    rst = 1'b0;
    step();

    // Game 1
    do_start(PB1, CB1);
    chk("start_state",   32'(state), 32'd1);
    chk("start_p_ready", 32'(p_ready), 32'd1);
    chk("start_pl",      32'(player_left), 32'd1);
    chk("start_cl",      32'(cpu_left), 32'd2);
    // c_valid aimed at the player ship while it is the player's turn is ignored
    c_valid = 1'b1; c_row = 3'd0; c_col = 3'd0;
    shot(1'b0, 3'd1, 3'd1, 1'b1, 5'd1, 5'd1);
    chk("cpu_left_after_hit", 32'(cpu_left), 32'd1);
    chk("pl_not_consumed",    32'(player_left), 32'd1);
    step();
    chk("c_turn_state", 32'(state), 32'd2);
    chk("c_turn_turn",  32'(turn), 32'd1);
    chk("c_turn_ready", 32'({p_ready, c_ready}), 32'b01);

    shot(1'b1, 3'd4, 3'd4, 1'b0, 5'd1, 5'd1);      // CPU miss
    step();
    chk("p_turn_again", 32'(state), 32'd1);
    chk("p_turn_turn",  32'(turn), 32'd0);
    shot(1'b0, 3'd1, 3'd1, 1'b0, 5'd1, 5'd1);      // repeated cell
    step();
    chk("c_turn_repeat", 32'(state), 32'd2);
    shot(1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd1);      // CPU miss
    step();
    shot(1'b0, 3'd5, 3'd0, 1'b0, 5'd1, 5'd1);      // row out of range
    step();
    chk("c_turn_oor", 32'(state), 32'd2);
    shot(1'b1, 3'd0, 3'd0, 1'b1, 5'd0, 5'd1);      // CPU sinks the fleet
    chk("pl_zero", 32'(player_left), 32'd0);
    step();
    chk("over_state",  32'(state), 32'd4);
    chk("over_flags",  32'({game_over, winner}), 32'b11);
    chk("over_ready",  32'({p_ready, c_ready}), 32'd0);
    p_valid = 1'b1; c_valid = 1'b1;                 // no shot may be taken in OVER
    step(); step();
    p_valid = 1'b0; c_valid = 1'b0;
    chk("over_hold", 32'({state, player_left, cpu_left}), 32'({3'd4, 5'd0, 5'd1}));

    // Game 2: restart from OVER; start held into P_TURN must be ignored
    do_start(25'h100_0008, 25'h100_0000);           // player (0,3),(4,4); cpu (4,4)
    chk("restart_state", 32'(state), 32'd1);
    chk("restart_cnts",  32'({player_left, cpu_left}), 32'({5'd2, 5'd1}));
    chk("restart_go",    32'(game_over), 32'd0);
    do_start(25'h1FF_FFFF, 25'h1FF_FFFF);
    chk("start_ignored", 32'({state, player_left, cpu_left}), 32'({3'd1, 5'd2, 5'd1}));
    shot(1'b0, 3'd4, 3'd4, 1'b1, 5'd2, 5'd0);
    step();
    chk("p_win", 32'({state, game_over, winner}), 32'({3'd4, 1'b1, 1'b0}));

    // Empty fleets at start go straight to OVER
    do_start(25'h3, 25'h0);
    chk("cpu_empty", 32'({state, winner}), 32'({3'd4, 1'b0}));
    do_start(25'h0, 25'h3);
    chk("player_empty", 32'({state, winner}), 32'({3'd4, 1'b1}));
    do_start(25'h0, 25'h0);
    chk("tie_empty", 32'({state, winner, player_left, cpu_left}), 32'({3'd4, 1'b0, 5'd0, 5'd0}));

`ifdef TURN_TIMEOUT_EN
    // Player idles 16 cycles and forfeits; CPU misses; player shoots in its last cycle
    do_start(PB1, CB1);
    exp_q.push_back('{hit: 1'b0, forf: 1'b1, pl: 5'd1, cl: 5'd2});
    repeat (15) step();
    chk("tmo_still_p", 32'(state), 32'd1);
    step();
    chk("tmo_switch", 32'(state), 32'd3);
    step();
    chk("tmo_c_turn", 32'(state), 32'd2);
    shot(1'b1, 3'd3, 3'd3, 1'b0, 5'd1, 5'd2);
    step();
    repeat (15) step();
    chk("tmo_last_p", 32'(state), 32'd1);
    shot(1'b0, 3'd2, 3'd2, 1'b1, 5'd1, 5'd1);
    step();
    chk("tmo_after_shot", 32'(state), 32'd2);
`else
    // Without a timeout a turn waits indefinitely
    do_start(PB1, CB1);
    repeat (20) step();
    chk("no_tmo_wait", 32'({state, p_ready}), 32'({3'd1, 1'b1}));
`endif

    // Reset asserted mid-shot: asynchronous return to IDLE, no shot applied
    do_start(PB1, CB1);
    p_valid = 1'b1; p_row = 3'd1; p_col = 3'd1;
    #2 rst = 1'b1;
    #1;
    chk("arst_state",  32'(state), 32'd0);
    chk("arst_counts", 32'({player_left, cpu_left}), 32'd0);
    chk("arst_ready",  32'({p_ready, c_ready}), 32'd0);
    step();
    p_valid = 1'b0;
    rst = 1'b0;
    step(); step();
    chk("arst_idle", 32'({state, shot_done}), 32'd0);

    step();
    done = 1'b1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
